syncnt_timer_ctrl: RTL and testbench
====================================

Name: syncnt_timer_ctrl

Overview:
- Sequencer for a WIDTH-bit synchronous load/clear up-counter built from SYNCNT-style cells: load active-low, clear active-high, clear beats load.
- Holds a reload register and drives the counter's LDL, CLR and count-enable.
- Provides one-shot and periodic interval timing, a terminal-count strobe and a sticky interrupt.
- Sits between the CPU register decode and the timer counter chain in Slipstream.

Parameters:
WIDTH, 16, counter and reload register width in bits (minimum 2)

Ports:
CLK  in  1  system clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
DIN  in  WIDTH  reload value for the reload register
WR_RELOAD  in  1  write strobe; DIN is captured into RELOAD
START  in  1  start or restart pulse
STOP  in  1  stop pulse
MODE  in  1  0 = one-shot, 1 = periodic; sampled every cycle
CE  in  1  count tick enable (prescaler strobe)
CLR_CNT  in  1  counter clear request
IRQ_ACK  in  1  clears IRQ
COUNT  out  WIDTH  current counter value
TC  out  1  registered one-cycle terminal-count strobe
IRQ  out  1  sticky interrupt flag
BUSY  out  1  high in LOADING or RUNNING

Behaviour:
- Reset (synchronous): state IDLE, COUNT=0, RELOAD=0, TC=0, IRQ=0, BUSY=0. Reset overrides every other input in the same cycle.
- RELOAD register:
  - WR_RELOAD=1 loads DIN at the next edge.
  - A load in the same cycle uses the old RELOAD value. The new value applies from the next load.
- States: IDLE, LOADING, RUNNING, DONE.
- IDLE or DONE with START=1 -> LOADING. COUNT is unchanged on this edge.
- LOADING:
  - Counter LDL is low for exactly one cycle, so COUNT=RELOAD at the next edge.
  - Next state is RUNNING.
  - CE is ignored.
- RUNNING, CE=1, COUNT not all-ones: COUNT increments by 1.
- RUNNING, CE=1, COUNT all-ones (expiry):
  - TC=1 on the following cycle, for one cycle only.
  - IRQ is set.
  - Periodic: COUNT loads RELOAD in the same edge, with no wrap through 0. State stays RUNNING.
  - One-shot: COUNT clears to 0 and state goes to DONE.
- Timing: the period is 2^WIDTH - RELOAD CE ticks. RELOAD = all-ones gives a period of 1 tick.
- RUNNING, CE=0: COUNT holds.
- START while RUNNING or LOADING: restart by going to LOADING. No TC is generated for that cycle, even if expiry coincides.
- STOP=1 in any state:
  - Next state IDLE; COUNT holds.
  - A pending expiry in that same cycle is suppressed: no TC, no IRQ.
  - STOP wins over a simultaneous START.
- CLR_CNT=1:
  - COUNT goes to 0 at the next edge; state is unchanged.
  - It overrides a LOADING load and a periodic reload in the same cycle, matching the datapath rule that clear beats load.
  - Expiry logic evaluates COUNT before the clear; STOP still suppresses.
- IRQ:
  - Set on expiry; cleared by IRQ_ACK.
  - Set wins over IRQ_ACK in the same cycle.
- BUSY is combinational from the state register.
- MODE change mid-run takes effect at the next expiry.
- All counter arithmetic is modulo 2^WIDTH. No other wrap path exists.

Decomposition:
- Package slip_timer_pkg:
  - state enum (IDLE, LOADING, RUNNING, DONE)
  - MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1
  - function all_ones(WIDTH)
- Sub-module syncnt_datapath (one instance):
  - Ports: D, LDL (active-low), CLR (active-high), INC, Q.
  - Priority: CLR > load > INC.
  - The controller drives only this interface.

Test Plan:
- WIDTH=4: RESET high for 2 cycles with random inputs -> COUNT=0, IRQ=0, TC=0, BUSY=0, state IDLE.
- WIDTH=4, RELOAD=12, MODE=1, START, CE always high:
  - COUNT sequence is 12,13,14,15,12,13,...
  - TC pulses every 4 cycles, one cycle after each 15.
  - IRQ is set after the first pulse and stays set until IRQ_ACK.
- WIDTH=4, RELOAD=14, MODE=0, CE every 3rd cycle:
  - COUNT goes 14,15,0, then state DONE, BUSY=0.
  - Exactly one TC; a further CE causes no change.
- WIDTH=4, RUNNING at COUNT=15 with CE=1 and STOP=1 in the same cycle -> no TC, no IRQ, IDLE, COUNT=15.
- WIDTH=4, CLR_CNT during LOADING with RELOAD=9 -> COUNT=0 (not 9), state RUNNING. Next CE gives COUNT=1.
- WIDTH=4, expiry and IRQ_ACK in the same cycle -> IRQ remains 1. WR_RELOAD=5 coinciding with a periodic reload -> that reload uses the old value; the next reload uses 5.

Source files
------------

// File: rtl/slip_timer_pkg.sv
// Shared types and helpers for the Slipstream interval timer sequencer.
package slip_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADING = 2'd1,
      ST_RUNNING = 2'd2,
      ST_DONE    = 2'd3
   } timer_state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Widest counter the helper below can describe.
   localparam int MAX_WIDTH = 64;

   // All-ones pattern of the given width, zero-extended to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/syncnt_datapath.sv
// Synchronous load/clear up-counter modelled on a chain of SYNCNT cells.
// Clear (active-high) beats load (active-low), which beats increment.
module syncnt_datapath #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_ldl,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Counter register with clear > load > increment priority.
   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_q <= '0;
      else if (!i_ldl)
         r_q <= i_d;
      else if (i_inc)
         r_q <= r_q + WIDTH'(1);
   end

   assign o_q = r_q;

endmodule

// File: rtl/syncnt_timer_ctrl.sv
// Interval timer sequencer: owns the reload register and drives the
// counter datapath's LDL / CLR / INC controls.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | stopped, counter holds
//   ST_LOADING | one cycle with LDL low, counter takes the reload value
//   ST_RUNNING | counting CE ticks toward all-ones
//   ST_DONE    | one-shot expired, counter cleared, waiting for START
//
// Reset is routed through the datapath's synchronous clear so the counter
// needs no reset pin of its own.
module syncnt_timer_ctrl
   import slip_timer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_wr_reload,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_mode,
   input  logic             i_ce,
   input  logic             i_clr_cnt,
   input  logic             i_irq_ack,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_irq,
   output logic             o_busy
);

   timer_state_e r_state;
   timer_state_e w_next_state;

   logic [WIDTH-1:0]     r_reload;
   logic                 r_tc;
   logic                 r_irq;

   logic [WIDTH-1:0]     w_count;
   logic [MAX_WIDTH-1:0] w_count_ext;
   logic                 w_at_top;
   logic                 w_tick;
   logic                 w_expiry;
   logic                 w_ldl;
   logic                 w_clr;
   logic                 w_inc;

   // Zero-extend the count so it can be compared against the package mask.
   always_comb begin
      w_count_ext              = '0;
      w_count_ext[WIDTH-1:0]   = w_count;
   end

   assign w_at_top = (w_count_ext == all_ones(WIDTH));

   // A tick only counts while running and no START/STOP is taking over.
   assign w_tick   = (r_state == ST_RUNNING) && i_ce && !i_start && !i_stop;
   assign w_expiry = w_tick && w_at_top;

   // Next-state and datapath control decode.
   always_comb begin
      w_next_state = r_state;
      w_ldl        = 1'b1;
      w_clr        = 1'b0;
      w_inc        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_next_state = ST_IDLE;
         end
         ST_LOADING: begin
            if (!i_stop) w_ldl = 1'b0;
            w_next_state = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (w_expiry) begin
               if (i_mode == MODE_PERIODIC) begin
                  w_ldl = 1'b0;
               end else begin
                  w_clr        = 1'b1;
                  w_next_state = ST_DONE;
               end
            end else if (w_tick) begin
               w_inc = 1'b1;
            end
         end
         ST_DONE: begin
            w_next_state = ST_DONE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      if (i_start) w_next_state = ST_LOADING;
      if (i_stop)  w_next_state = ST_IDLE;

      // Explicit clear and reset both win over any load in the datapath.
      if (i_clr_cnt || i_reset) w_clr = 1'b1;
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Reload register; a load on the same edge still sees the old value.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_reload <= '0;
      else if (i_wr_reload)
         r_reload <= i_din;
   end

   // Terminal-count strobe and sticky interrupt; a new expiry beats the ack.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tc  <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_tc <= w_expiry;
         if (w_expiry)
            r_irq <= 1'b1;
         else if (i_irq_ack)
            r_irq <= 1'b0;
      end
   end

   syncnt_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .i_clk (i_clk),
      .i_d   (r_reload),
      .i_ldl (w_ldl),
      .i_clr (w_clr),
      .i_inc (w_inc),
      .o_q   (w_count)
   );

   assign o_count = w_count;
   assign o_tc    = r_tc;
   assign o_irq   = r_irq;
   assign o_busy  = (r_state == ST_LOADING) || (r_state == ST_RUNNING);

endmodule

// File: tb/tb_syncnt_timer_ctrl.sv
// Directed bench for the interval timer at WIDTH=4. Stimulus pushes the
// expected post-edge outputs into a queue; a monitor pops and compares.
module tb_syncnt_timer_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         wr, start, stop, mode, ce, clr, ack;
   logic [W-1:0] o_count;
   logic         o_tc, o_irq, o_busy;

   typedef struct packed {
      logic [W-1:0] count;
      logic         tc;
      logic         irq;
      logic         busy;
   } exp_t;

   exp_t  sb[$];
   string nq[$];
   int    vectors = 0;
   int    miscompares = 0;

   syncnt_timer_ctrl #(.WIDTH(W)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_din       (din),
      .i_wr_reload (wr),
      .i_start     (start),
      .i_stop      (stop),
      .i_mode      (mode),
      .i_ce        (ce),
      .i_clr_cnt   (clr),
      .i_irq_ack   (ack),
      .o_count     (o_count),
      .o_tc        (o_tc),
      .o_irq       (o_irq),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Queue the expected result of the coming edge, apply it, drop pulses.
   task automatic tick(input logic [W-1:0] c, input logic t, input logic q,
                       input logic b, input string nm);
      exp_t e;
      e.count = c; e.tc = t; e.irq = q; e.busy = b;
      sb.push_back(e);
      nq.push_back(nm);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clr = 1'b0; ack = 1'b0; wr = 1'b0;
   endtask

   // Monitor: compare the DUT after every edge that has an expectation.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = nq.pop_front();
            vectors++;
            if ({o_count, o_tc, o_irq, o_busy} !== e) begin
               miscompares++;
               $display("FAIL %s: got count=%0d tc=%0b irq=%0b busy=%0b, expected count=%0d tc=%0b irq=%0b busy=%0b",
                        nm, o_count, o_tc, o_irq, o_busy, e.count, e.tc, e.irq, e.busy);
            end
         end
      end
   end

   initial begin
      // Reset for two cycles with random stimulus on every other input.
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1;
         din = W'($urandom_range(0, 15));
         {wr, start, stop, mode, ce, clr, ack} = 7'($urandom_range(0, 127));
         tick(0, 0, 0, 0, "reset");
      end
      rst = 1'b0; din = '0;
      wr = 0; start = 0; stop = 0; mode = 0; ce = 0; clr = 0; ack = 0;
      tick(0, 0, 0, 0, "idle_after_reset");

      // Periodic, reload 12, CE always high.
      wr = 1; din = 4'd12;       tick(0,  0, 0, 0, "wr_reload12");
      mode = 1; ce = 1; start = 1; tick(0, 0, 0, 1, "start_to_loading");
      tick(12, 0, 0, 1, "load12");
      tick(13, 0, 0, 1, "per_13");
      tick(14, 0, 0, 1, "per_14");
      tick(15, 0, 0, 1, "per_15");
      tick(12, 1, 1, 1, "per_expiry1");
      tick(13, 0, 1, 1, "per_tc_one_cycle");
      tick(14, 0, 1, 1, "per_14b");
      tick(15, 0, 1, 1, "per_15b");
      tick(12, 1, 1, 1, "per_expiry2");
      ack = 1;                   tick(13, 0, 0, 1, "irq_ack_clears");
      tick(14, 0, 0, 1, "per_14c");
      tick(15, 0, 0, 1, "per_15c");
      ack = 1;                   tick(12, 1, 1, 1, "expiry_beats_ack");
      tick(13, 0, 1, 1, "per_13d");
      tick(14, 0, 1, 1, "per_14d");
      tick(15, 0, 1, 1, "per_15d");
      wr = 1; din = 4'd5;        tick(12, 1, 1, 1, "reload_uses_old");
      tick(13, 0, 1, 1, "per_13e");
      tick(14, 0, 1, 1, "per_14e");
      tick(15, 0, 1, 1, "per_15e");
      tick(5,  1, 1, 1, "reload_uses_new");
      tick(6,  0, 1, 1, "per_6");
      stop = 1;                  tick(6, 0, 1, 0, "stop_holds_count");
      ack = 1;                   tick(6, 0, 0, 0, "ack_in_idle");

      // One-shot, reload 14, CE every third cycle.
      ce = 0; wr = 1; din = 4'd14; tick(6, 0, 0, 0, "wr_reload14");
      mode = 0; start = 1;       tick(6,  0, 0, 1, "os_start");
      tick(14, 0, 0, 1, "os_load14");
      tick(14, 0, 0, 1, "os_hold_a");
      tick(14, 0, 0, 1, "os_hold_b");
      ce = 1;                    tick(15, 0, 0, 1, "os_15");
      ce = 0;                    tick(15, 0, 0, 1, "os_hold_c");
      tick(15, 0, 0, 1, "os_hold_d");
      ce = 1;                    tick(0,  1, 1, 0, "os_expiry_done");
      ce = 0;                    tick(0,  0, 1, 0, "os_single_tc");
      tick(0,  0, 1, 0, "os_done_hold");
      ce = 1;                    tick(0,  0, 1, 0, "done_ce_no_change");
      ce = 0; ack = 1;           tick(0,  0, 0, 0, "ack_in_done");

      // STOP coinciding with expiry at 15.
      mode = 1; start = 1;       tick(0,  0, 0, 1, "start_from_done");
      ce = 1;                    tick(14, 0, 0, 1, "load_ignores_ce");
      tick(15, 0, 0, 1, "run_to_15");
      stop = 1;                  tick(15, 0, 0, 0, "stop_suppresses_expiry");
      tick(15, 0, 0, 0, "idle_no_late_tc");

      // CLR_CNT during LOADING beats the load.
      ce = 0; wr = 1; din = 4'd9; tick(15, 0, 0, 0, "wr_reload9");
      start = 1;                 tick(15, 0, 0, 1, "start_keeps_count");
      clr = 1;                   tick(0,  0, 0, 1, "clr_beats_load");
      ce = 1;                    tick(1,  0, 0, 1, "inc_after_clr");
      tick(2,  0, 0, 1, "inc_2");

      // START coinciding with expiry restarts without a TC.
      stop = 1;                  tick(2,  0, 0, 0, "stop_at_2");
      ce = 0; wr = 1; din = 4'd14; tick(2, 0, 0, 0, "wr_reload14b");
      start = 1;                 tick(2,  0, 0, 1, "start_b");
      ce = 1;                    tick(14, 0, 0, 1, "load14b");
      tick(15, 0, 0, 1, "run_15b");
      start = 1;                 tick(15, 0, 0, 1, "restart_at_expiry");
      tick(14, 0, 0, 1, "reload_after_restart");
      tick(15, 0, 0, 1, "run_15c");
      tick(14, 1, 1, 1, "expiry_after_restart");

      // Let the monitor drain, within a bounded number of cycles.
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
